rc4_prga_checker: RTL
=====================

RC4_PRGA_CHECKER -- requirements
Module: rc4_prga_checker

Interface
REQ-001 SHALL have parameter MSG_DEP, default 32: message length in bytes.
REQ-002 SHALL have parameter ADDR_W, default 8: S-box address width; S depth is 2^ADDR_W; DATA_W is fixed at 8.
REQ-003 SHALL have parameter CHECK_EN, default 1: when 1, enables the plaintext range check and early abort.
REQ-004 SHALL have parameter CHAR_LO, default 8'h61: lowest legal plaintext byte.
REQ-005 SHALL have parameter CHAR_HI, default 8'h7A: highest legal plaintext byte. Byte 8'h20 is always legal.
REQ-006 SHALL have port: clk  in  1  single clock; all state changes on the rising edge.
REQ-007 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port: start  in  1  level request to begin; sampled only in IDLE and DONE.
REQ-009 SHALL have port: s_addr  out  ADDR_W  S RAM address.
REQ-010 SHALL have port: s_rdata  in  8  S RAM read data.
REQ-011 SHALL have port: s_wdata  out  8  S RAM write data.
REQ-012 SHALL have port: s_wren  out  1  S RAM write enable.
REQ-013 SHALL have port: m_addr  out  $clog2(MSG_DEP)  ciphertext ROM address.
REQ-014 SHALL have port: m_rdata  in  8  ciphertext ROM read data.
REQ-015 SHALL have port: d_addr  out  $clog2(MSG_DEP)  plaintext RAM address.
REQ-016 SHALL have port: d_wdata  out  8  plaintext RAM write data.
REQ-017 SHALL have port: d_wren  out  1  plaintext RAM write enable.
REQ-018 SHALL have outputs: busy  out  1; done  out  1; pass  out  1; fail  out  1.

Function
REQ-019 SHALL treat every memory as synchronous with a read latency of 1: read data in cycle t+1 reflects the address in cycle t. All outputs SHALL be registered.
REQ-020 SHALL process each byte k = 0..MSG_DEP-1 as follows:
- i = i+1; si = S[i]
- j = j+si; sj = S[j]
- write S[i] = sj, then write S[j] = si
- f = S[(si+sj) mod 2^ADDR_W]
- d[k] = f XOR m[k]
REQ-021 SHALL start each run with i = j = 0, wrap all index arithmetic modulo 2^ADDR_W, and not reinitialise S (S is preloaded upstream).
REQ-022 SHALL implement these states, one cycle each, in this order: IDLE, RD_SI, WT_SI, RD_SJ, WT_SJ, WR_I, WR_J, RD_F, WT_F, XOR_WR, CHECK, DONE. Each byte therefore takes exactly 10 cycles.
REQ-023 SHALL perform the following state actions:
- RD_SI: drive s_addr = i+1.
- RD_SJ: capture si and j, drive s_addr = j.
- WR_I: capture sj and assert s_wren.
- WR_J: assert s_wren.
- RD_F: drive s_addr and m_addr.
- XOR_WR: assert d_wren with d_addr = k.
- CHECK: evaluate the range check.
REQ-024 SHALL hold s_wren high only in WR_I and WR_J, and d_wren high only in XOR_WR; each is a single-cycle pulse.
REQ-025 In CHECK, when CHECK_EN = 1 and d[k] is outside [CHAR_LO, CHAR_HI] and not 8'h20, SHALL go to DONE with fail = 1; the byte is still written.
REQ-026 In CHECK, when k = MSG_DEP-1 and no failure occurred, SHALL go to DONE with pass = 1; otherwise it SHALL go to RD_SI with k+1.
REQ-027 On a passing run, SHALL assert done exactly 10*MSG_DEP+1 cycles after the start-accept edge.
REQ-028 SHALL hold busy = 1 in every state except IDLE and DONE; start SHALL be ignored while busy.
REQ-029 SHALL hold done, pass and fail stable in DONE until start is sampled high. The restart SHALL clear done, pass, fail, i, j and k, then enter RD_SI.
REQ-030 SHALL keep pass and fail mutually exclusive; neither SHALL be asserted outside DONE.
REQ-031 SHALL map any illegal state encoding to IDLE on the next edge.

Reset
REQ-032 While reset = 0, SHALL immediately force state = IDLE, all other outputs = 0 (busy, done, pass, fail, s_wren, d_wren, all addresses and write data), and i = j = k = 0.
REQ-033 Reset asserted mid-run SHALL abort the run with no further memory writes. Any partially swapped S is not restored.

Verification
REQ-034 SHALL pass this scenario: identity S (S[x] = x), m all 8'h00, CHECK_EN = 0, start -> d[0] = 8'h02, d[1] = 8'h05, S[2] = 3, S[3] = 2 after byte 1, pass = 1.
REQ-035 SHALL pass this scenario: S preloaded with the KSA of key "Key", MSG_DEP = 9, m = BB F3 16 E8 D9 40 AF 0A D3, CHECK_EN = 0 -> d = "Plaintext", done at cycle 91, pass = 1.
REQ-036 SHALL pass this scenario: same stimulus as REQ-035 with CHECK_EN = 1 -> fail = 1 after byte 0 ('P' = 8'h50 is illegal), exactly one d_wren pulse, done at cycle 11.
REQ-037 SHALL pass this scenario: reset driven low during WR_I of byte 3 -> outputs zero asynchronously, no further s_wren or d_wren, IDLE on release.
REQ-038 SHALL pass this scenario: start pulsed during RD_F -> ignored, run completes normally; start high in DONE -> flags clear and a new run begins with i = j = 0.
REQ-039 SHALL pass this scenario: ADDR_W = 4, identity S, 40-byte run -> i and j wrap modulo 16, and no s_addr above 15 is ever driven.

Source files
------------

// File: rtl/rc4_prga_checker.sv
// rc4_prga_checker: RC4 keystream generator that decrypts a ciphertext ROM into a plaintext RAM,
// optionally aborting as soon as a decrypted byte falls outside the legal character range.
module rc4_prga_checker #(
    parameter int MSG_DEP = 32,
    parameter int ADDR_W = 8,
    parameter bit CHECK_EN = 1'b1,
    parameter logic [7:0] CHAR_LO = 8'h61,
    parameter logic [7:0] CHAR_HI = 8'h7A
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic [ADDR_W-1:0]          s_addr,
    input  logic [7:0]                 s_rdata,
    output logic [7:0]                 s_wdata,
    output logic                       s_wren,
    output logic [$clog2(MSG_DEP)-1:0] m_addr,
    input  logic [7:0]                 m_rdata,
    output logic [$clog2(MSG_DEP)-1:0] d_addr,
    output logic [7:0]                 d_wdata,
    output logic                       d_wren,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       fail
);
    localparam int KW = $clog2(MSG_DEP);

    typedef enum logic [3:0] {
        IDLE, RD_SI, WT_SI, RD_SJ, WT_SJ, WR_I, WR_J, RD_F, WT_F, XOR_WR, CHECK, DONE
    } state_t;

    state_t state;
    logic [ADDR_W-1:0] i, j;
    logic [7:0] si, sj;
    logic [KW-1:0] k;
    logic legal, last;

    assign legal = d_wdata == 8'h20 || (d_wdata >= CHAR_LO && d_wdata <= CHAR_HI);
    assign last = k == KW'(MSG_DEP - 1);

    // Outputs are registered, so each state's memory controls are loaded on the edge entering it.
    // i therefore already holds the incremented index for the current byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            si      <= '0;
            sj      <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wren  <= 1'b0;
            m_addr  <= '0;
            d_addr  <= '0;
            d_wdata <= '0;
            d_wren  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            fail    <= 1'b0;
        end else begin
            s_wren <= 1'b0;
            d_wren <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    state  <= RD_SI;
                    busy   <= 1'b1;
                    done   <= 1'b0;
                    pass   <= 1'b0;
                    fail   <= 1'b0;
                    i      <= ADDR_W'(1);
                    j      <= '0;
                    k      <= '0;
                    s_addr <= ADDR_W'(1);
                end
                RD_SI: state <= WT_SI;
                WT_SI: begin
                    state  <= RD_SJ;
                    si     <= s_rdata;
                    j      <= j + ADDR_W'(s_rdata);
                    s_addr <= j + ADDR_W'(s_rdata);
                end
                RD_SJ: state <= WT_SJ;
                WT_SJ: begin
                    state   <= WR_I;
                    sj      <= s_rdata;
                    s_addr  <= i;
                    s_wdata <= s_rdata;
                    s_wren  <= 1'b1;
                end
                WR_I: begin
                    state   <= WR_J;
                    s_addr  <= j;
                    s_wdata <= si;
                    s_wren  <= 1'b1;
                end
                WR_J: begin
                    state  <= RD_F;
                    s_addr <= ADDR_W'(si) + ADDR_W'(sj);
                    m_addr <= k;
                end
                RD_F: state <= WT_F;
                WT_F: begin
                    state   <= XOR_WR;
                    d_wdata <= s_rdata ^ m_rdata;
                    d_addr  <= k;
                    d_wren  <= 1'b1;
                end
                XOR_WR: state <= CHECK;
                CHECK: begin
                    if ((CHECK_EN && !legal) || last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        fail  <= CHECK_EN && !legal;
                        pass  <= !(CHECK_EN && !legal);
                    end else begin
                        state  <= RD_SI;
                        k      <= k + KW'(1);
                        i      <= i + ADDR_W'(1);
                        s_addr <= i + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
